// File: rtl/fifo_ctrl_pkg.sv
// Shared constants, state encoding and pointer helpers for the 8-entry FIFO controller.
package fifo_ctrl_pkg;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } state_t;

    // Power-of-two depth, so the natural AW-bit overflow gives the 7 -> 0 wrap.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Push/pop request and status bundle between a FIFO user and the pointer controller.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
    ();

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wAddr;
    logic          we;
    logic [AW-1:0] rAddr;
    logic          re;
    logic          full;
    logic          empty;
    logic [AW:0]   data_count;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    modport master (
        output wr_en, rd_en,
        input  wAddr, we, rAddr, re, full, empty, data_count,
        input  wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  wr_en, rd_en,
        output wAddr, we, rAddr, re, full, empty, data_count,
        output wr_ack, wr_err, rd_ack, rd_err
    );

endinterface

// File: rtl/fifo_ctrl_next_state.sv
// Combinational next-state decision from the current requests and occupancy.
module fifo_ctrl_next_state
    import fifo_ctrl_pkg::*;
(
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [AW:0] data_count,
    output state_t      state_next
);

    // Simultaneous or absent requests are a no-op; otherwise the count decides accept vs reject.
    always_comb begin
        state_next = ST_NO_OP;
        if (wr_en && !rd_en) begin
            state_next = (data_count < DEPTH_CNT) ? ST_WRITE : ST_WR_ERROR;
        end else if (rd_en && !wr_en) begin
            state_next = (data_count != '0) ? ST_READ : ST_RD_ERROR;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Head/tail/occupancy controller for the 8-entry register-file FIFO: drives write/read
// addresses and strobes, and reports per-request ack/error one cycle after the request edge.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    fifo_ctrl_if.slave  bus
);

    state_t        state_reg;
    state_t        state_next;
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [AW:0]   count_reg;

    fifo_ctrl_next_state u_next_state (
        .wr_en      (bus.wr_en),
        .rd_en      (bus.rd_en),
        .data_count (count_reg),
        .state_next (state_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_INIT;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_next)
                ST_WRITE: begin
                    tail_reg  <= ptr_inc(tail_reg);
                    count_reg <= count_reg + (AW + 1)'(1);
                end
                ST_READ: begin
                    head_reg  <= ptr_inc(head_reg);
                    count_reg <= count_reg - (AW + 1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Strobes follow the same-cycle decision; gating with reset_n keeps them low during reset.
    assign bus.we         = reset_n && (state_next == ST_WRITE);
    assign bus.re         = reset_n && (state_next == ST_READ);
    assign bus.wAddr      = tail_reg;
    assign bus.rAddr      = head_reg;

    assign bus.data_count = count_reg;
    assign bus.full       = (count_reg == DEPTH_CNT);
    assign bus.empty      = (count_reg == '0);

    assign bus.wr_ack     = (state_reg == ST_WRITE);
    assign bus.wr_err     = (state_reg == ST_WR_ERROR);
    assign bus.rd_ack     = (state_reg == ST_READ);
    assign bus.rd_err     = (state_reg == ST_RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed fill/drain/wrap/reset cases plus random traffic
// compared against a queue-based model of the FIFO occupancy.
module tb_fifo_ctrl;

    logic clk;
    logic reset_n;

    fifo_ctrl_if bus ();

    fifo_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam int D_NONE = 0;
    localparam int D_WR   = 1;
    localparam int D_WERR = 2;
    localparam int D_RD   = 3;
    localparam int D_RERR = 4;

    int m_q[$];       // slot indices currently holding data, oldest first
    int m_wr_ptr;     // slot the next accepted push lands in
    int m_prev;       // decision taken at the previous edge

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wr_ptr = 0;
        m_prev   = D_NONE;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".empty"},      32'(bus.empty),      1);
        check_eq({tag, ".full"},       32'(bus.full),       0);
        check_eq({tag, ".data_count"}, 32'(bus.data_count), 0);
        check_eq({tag, ".wAddr"},      32'(bus.wAddr),      0);
        check_eq({tag, ".rAddr"},      32'(bus.rAddr),      0);
        check_eq({tag, ".we"},         32'(bus.we),         0);
        check_eq({tag, ".re"},         32'(bus.re),         0);
        check_eq({tag, ".acks"},
                 32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 0);
    endtask

    // One clock of traffic: drive requests, check every output against the model, then
    // advance the model at the edge.
    task automatic step(input string tag, input logic w, input logic r);
        int dec;
        int cnt;
        @(negedge clk);
        bus.wr_en = w;
        bus.rd_en = r;
        #1;
        cnt = m_q.size();
        if (w && !r)      dec = (cnt < 8) ? D_WR : D_WERR;
        else if (r && !w) dec = (cnt > 0) ? D_RD : D_RERR;
        else              dec = D_NONE;

        check_eq({tag, ".we"},         32'(bus.we),         32'(dec == D_WR));
        check_eq({tag, ".re"},         32'(bus.re),         32'(dec == D_RD));
        check_eq({tag, ".wAddr"},      32'(bus.wAddr),      32'(m_wr_ptr));
        check_eq({tag, ".rAddr"},      32'(bus.rAddr),      32'((cnt > 0) ? m_q[0] : m_wr_ptr));
        check_eq({tag, ".data_count"}, 32'(bus.data_count), 32'(cnt));
        check_eq({tag, ".full"},       32'(bus.full),       32'(cnt == 8));
        check_eq({tag, ".empty"},      32'(bus.empty),      32'(cnt == 0));
        check_eq({tag, ".wr_ack"},     32'(bus.wr_ack),     32'(m_prev == D_WR));
        check_eq({tag, ".wr_err"},     32'(bus.wr_err),     32'(m_prev == D_WERR));
        check_eq({tag, ".rd_ack"},     32'(bus.rd_ack),     32'(m_prev == D_RD));
        check_eq({tag, ".rd_err"},     32'(bus.rd_err),     32'(m_prev == D_RERR));

        @(posedge clk);
        if (dec == D_WR) begin
            m_q.push_back(m_wr_ptr);
            m_wr_ptr = (m_wr_ptr + 1) % 8;
        end else if (dec == D_RD) begin
            void'(m_q.pop_front());
        end
        m_prev = dec;
        $display("[TB] %s wr=%0b rd=%0b count=%0d wAddr=%0d rAddr=%0d", tag, w, r,
                 cnt, bus.wAddr, bus.rAddr);
    endtask

    // Asynchronous reset asserted mid-cycle while a push is being requested.
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check_reset_values({tag, ".held"});
        reset_n = 1'b1;
        $display("[TB] %s async reset applied and released", tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        model_reset();
        #12 check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) step("fill", 1'b1, 1'b0);
        step("fill_idle", 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("drain", 1'b0, 1'b1);
        step("drain_idle", 1'b0, 1'b0);

        // Pointers sit at 0 here; advance to 5 so the next pushes wrap past 7.
        for (int i = 0; i < 5; i++) step("wrap_push5", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_pop5", 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step("wrap_push6", 1'b1, 1'b0);
        step("wrap_idle", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("sim_pop", 1'b0, 1'b1);
        step("sim_both", 1'b1, 1'b1);
        step("sim_after", 1'b1, 1'b1);
        step("sim_idle", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("midrst_push", 1'b1, 1'b0);
        async_reset("midrst");
        step("midrst_first", 1'b1, 1'b0);
        step("midrst_idle", 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (i == 200) async_reset("rand_rst");
            // Phases biased toward pushes then pops so the bench reaches full and empty.
            if (i % 80 < 40) step("rand", sel < 6, sel >= 4 && sel < 7);
            else             step("rand", sel >= 7, sel < 6);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
